// File: rtl/bne_seq_ctrl.sv
// bne_seq_ctrl: weight-load / image-stream sequencer for the
// binary neural engine, with a credit-gated result FIFO.
module bne_seq_ctrl #(
  parameter int AW         = 8,
  parameter int ENG_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] len,
  input  logic [AW-1:0] wgt_addr,
  input  logic [4:0]    op_cfg,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] sram_addr_r,
  output logic [4:0]    eng_opcode,
  output logic          eng_w_en,
  input  logic [6:0]    eng_result,
  output logic [6:0]    res_data,
  output logic          res_valid,
  input  logic          res_ready
);
  localparam int TD  = 1 + ENG_LAT;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CTW = PW + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + TD + 2) + 1;

  typedef enum logic [2:0] {
    IDLE, WLOAD, ISSUE, DRAIN, DONE
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] base_q;
  logic [AW-1:0] rem, rem_n;
  logic [AW-1:0] k, k_n;
  logic [AW-1:0] addr_n;
  logic [4:0]    op_q;
  logic [TD:0]   tag;
  logic          issue_n;

  logic          push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [PW:0]   cnt, cnt_n, left;
  logic [6:0]    mem [FIFO_DEPTH];
  logic [6:0]    head_n;
  logic [CW-1:0] inflight_n, occ_n;

  assign push  = tag[TD];
  assign pop   = res_valid & res_ready;
  assign cnt_n = cnt + CTW'(push) - CTW'(pop);
  assign left  = cnt - CTW'(pop);
  assign rd_n  = rd_ptr + PW'(pop);

  // tags still in flight after this edge (the exiting one is pushed)
  always_comb begin
    inflight_n = '0;
    for (int i = 0; i < TD; i++) begin
      inflight_n = inflight_n + CW'(tag[i]);
    end
  end

  assign occ_n = CW'(cnt_n) + inflight_n;

  always_comb begin
    state_n = state;
    rem_n   = rem;
    k_n     = k;
    addr_n  = sram_addr_r;
    issue_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_n = DONE;
          end else begin
            state_n = WLOAD;
            addr_n  = wgt_addr;
            rem_n   = len;
            k_n     = '0;
          end
        end
      end
      WLOAD, ISSUE: begin
        if (rem != '0 && occ_n < CW'(FIFO_DEPTH)) begin
          issue_n = 1'b1;
          addr_n  = base_q + k;
          k_n     = k + 1'b1;
          rem_n   = rem - 1'b1;
        end
        if (state == WLOAD) state_n = ISSUE;
        else if (rem == '0) state_n = DRAIN;
      end
      DRAIN: begin
        if (inflight_n == '0) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rem         <= '0;
      k           <= '0;
      base_q      <= '0;
      op_q        <= '0;
      sram_addr_r <= '0;
      tag         <= '0;
      eng_opcode  <= '0;
      eng_w_en    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      rem         <= rem_n;
      k           <= k_n;
      sram_addr_r <= addr_n;
      tag         <= {tag[TD-1:0], issue_n};
      eng_opcode  <= tag[0] ? op_q : 5'd0;
      eng_w_en    <= (state == WLOAD);
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
      if (state == IDLE && start) begin
        base_q <= base_addr;
        op_q   <= op_cfg;
      end
    end
  end

  // registered head: bypass the pushed word when the FIFO runs dry
  always_comb begin
    head_n = res_data;
    if (left != '0) head_n = mem[rd_n];
    else if (push) head_n = eng_result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_n;
      cnt       <= cnt_n;
      res_valid <= (cnt_n != '0);
      res_data  <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= eng_result;
  end

  a_no_ovf: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && cnt == CTW'(FIFO_DEPTH)))
    else $error("result fifo overflow");

endmodule

// File: tb/tb_bne_seq_ctrl.sv
// tb_bne_seq_ctrl: vector tables plus a result scoreboard
// against a small SRAM/engine model.
module tb_bne_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [7:0] len = '0;
  logic [7:0] wgt_addr = '0;
  logic [4:0] op_cfg = '0;
  logic       res_ready = 1'b0;
  logic       busy, done, eng_w_en, res_valid;
  logic [7:0] sram_addr_r;
  logic [4:0] eng_opcode;
  logic [6:0] eng_result, res_data;

  int errors = 0;
  int checks = 0;
  logic [6:0] sb[$];
  logic [6:0] sb_exp;
  logic [7:0] a1 = '0, a2 = '0;
  logic [4:0] o1 = '0;

  typedef struct {
    logic [7:0] addr;
    logic       w_en;
    logic [4:0] opc;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t       basic [1:8];
  logic [7:0] wrap_addr [1:5];

  always #5 clk = ~clk;

  bne_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .len(len),
    .wgt_addr(wgt_addr), .op_cfg(op_cfg),
    .busy(busy), .done(done),
    .sram_addr_r(sram_addr_r),
    .eng_opcode(eng_opcode), .eng_w_en(eng_w_en),
    .eng_result(eng_result),
    .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  function automatic logic [6:0] model(logic [7:0] a, logic [4:0] op);
    return a[6:0] ^ {op, 2'b01};
  endfunction

  // SRAM (1 cycle) then engine (ENG_LAT=1)
  always @(posedge clk) begin
    a1 <= sram_addr_r;
    a2 <= a1;
    o1 <= eng_opcode;
  end
  assign eng_result = model(a2, o1);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_result: got %0h expected none", res_data);
      end else begin
        sb_exp = sb.pop_front();
        check("result", 32'(res_data), 32'(sb_exp));
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_run(logic [7:0] b, logic [7:0] l, logic [4:0] op);
    for (int i = 0; i < int'(l); i++) sb.push_back(model(b + 8'(i), op));
  endtask

  task automatic kick(logic [7:0] b, logic [7:0] l,
                      logic [7:0] w, logic [4:0] op);
    base_addr = b;
    len       = l;
    wgt_addr  = w;
    op_cfg    = op;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check(name, 32'(seen), 32'd1);
    tick();
  endtask

  initial begin
    basic[1] = '{8'h10, 1'b0, 5'd0, 1'b0, 1'b1};
    basic[2] = '{8'h20, 1'b1, 5'd0, 1'b0, 1'b1};
    basic[3] = '{8'h21, 1'b0, 5'd5, 1'b0, 1'b1};
    basic[4] = '{8'h22, 1'b0, 5'd5, 1'b0, 1'b1};
    basic[5] = '{8'h22, 1'b0, 5'd5, 1'b0, 1'b1};
    basic[6] = '{8'h22, 1'b0, 5'd0, 1'b0, 1'b1};
    basic[7] = '{8'h22, 1'b0, 5'd0, 1'b1, 1'b1};
    basic[8] = '{8'h22, 1'b0, 5'd0, 1'b0, 1'b0};
    wrap_addr[1] = 8'h01;
    wrap_addr[2] = 8'hFE;
    wrap_addr[3] = 8'hFF;
    wrap_addr[4] = 8'h00;
    wrap_addr[5] = 8'h01;

    // reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      start     = 1'($urandom);
      base_addr = 8'($urandom);
      len       = 8'($urandom);
      wgt_addr  = 8'($urandom);
      op_cfg    = 5'($urandom);
      res_ready = 1'($urandom);
      @(negedge clk);
      check("reset_outs",
            32'({busy, done, sram_addr_r, eng_opcode,
                 eng_w_en, res_valid, res_data}), 32'd0);
      tick();
    end
    start     = 1'b0;
    len       = '0;
    res_ready = 1'b1;
    rst       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_valid", 32'(res_valid), 32'd0);
      tick();
    end

    // basic run
    expect_run(8'h20, 8'd3, 5'd5);
    kick(8'h20, 8'd3, 8'h10, 5'd5);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("basic_addr_c%0d", c), 32'(sram_addr_r), 32'(basic[c].addr));
      check($sformatf("basic_wen_c%0d", c), 32'(eng_w_en), 32'(basic[c].w_en));
      check($sformatf("basic_opc_c%0d", c), 32'(eng_opcode), 32'(basic[c].opc));
      check($sformatf("basic_done_c%0d", c), 32'(done), 32'(basic[c].done));
      check($sformatf("basic_busy_c%0d", c), 32'(busy), 32'(basic[c].busy));
      tick();
    end
    check("basic_drained", 32'(sb.size()), 32'd0);

    // backpressure: credit stops issue at FIFO_DEPTH
    res_ready = 1'b0;
    expect_run(8'h40, 8'd8, 5'd3);
    kick(8'h40, 8'd8, 8'h30, 5'd3);
    begin
      int n_iss = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (eng_opcode != 5'd0) n_iss++;
        tick();
      end
      check("bp_issues", 32'(n_iss), 32'd4);
    end
    @(negedge clk);
    check("bp_addr_hold", 32'(sram_addr_r), 32'h43);
    check("bp_valid", 32'(res_valid), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    tick();
    res_ready = 1'b1;
    wait_done("bp_done", 60);
    tick(3);
    check("bp_drained", 32'(sb.size()), 32'd0);
    check("bp_empty", 32'(res_valid), 32'd0);

    // zero length
    kick(8'h77, 8'd0, 8'h55, 5'd6);
    @(negedge clk);
    check("zl_done", 32'(done), 32'd1);
    check("zl_addr", 32'(sram_addr_r), 32'h47);
    check("zl_wen", 32'(eng_w_en), 32'd0);
    tick();
    @(negedge clk);
    check("zl_done_low", 32'(done), 32'd0);
    check("zl_busy", 32'(busy), 32'd0);
    check("zl_wen2", 32'(eng_w_en), 32'd0);
    check("zl_opc", 32'(eng_opcode), 32'd0);
    tick();

    // address wrap with an ignored second start
    expect_run(8'hFE, 8'd4, 5'd9);
    kick(8'hFE, 8'd4, 8'h01, 5'd9);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("wrap_addr_c%0d", c), 32'(sram_addr_r), 32'(wrap_addr[c]));
      tick();
      start = (c == 2);
      if (c == 2) begin
        base_addr = 8'h80;
        len       = 8'd2;
        wgt_addr  = 8'h90;
        op_cfg    = 5'd1;
      end
    end
    wait_done("wrap_done", 20);
    tick(4);
    @(negedge clk);
    check("wrap_no_rerun", 32'(sram_addr_r), 32'h01);
    check("wrap_idle", 32'(busy), 32'd0);
    check("wrap_drained", 32'(sb.size()), 32'd0);
    tick();

    // reset mid-run with two results queued
    res_ready = 1'b0;
    kick(8'h10, 8'd6, 8'h08, 5'd7);
    tick(5);
    @(negedge clk);
    check("mr_queued", 32'(res_valid), 32'd1);
    check("mr_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mr_valid_clr", 32'(res_valid), 32'd0);
    check("mr_busy_clr", 32'(busy), 32'd0);
    check("mr_addr_clr", 32'(sram_addr_r), 32'd0);
    tick(2);
    rst = 1'b1;
    tick();
    res_ready = 1'b1;
    expect_run(8'h50, 8'd2, 5'd2);
    kick(8'h50, 8'd2, 8'h44, 5'd2);
    wait_done("mr_done", 20);
    tick(3);
    check("mr_drained", 32'(sb.size()), 32'd0);
    check("mr_empty", 32'(res_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
